// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - framed byte-stream boot loader for the instruction memory
//
// Receives LEN_HI, LEN_LO, N*4 big-endian data bytes and an XOR CHECK byte.
// Writes each assembled word to the instruction memory and holds the CPU in
// reset until a complete, checksum-valid image has been loaded.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a new load (honoured only in IDLE, DONE, ERROR)
//   in_data/in_valid  host byte stream; in_ready signals acceptance
//   imem_we/waddr/wdata  one-cycle instruction memory write port
//   cpu_rst           CPU reset, low only in DONE
//   load_done/err     sticky load status
//   words_loaded      words written in the current load
module inst_loader #(
   parameter int unsigned         ADDR_LEN  = 32,
   parameter int unsigned         DATA_LEN  = 32,
   parameter logic [ADDR_LEN-1:0] BASE_ADDR = '0,
   parameter int unsigned         MAX_WORDS = 1024,
   parameter int unsigned         TIMEOUT   = 65535
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [7:0]          in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                imem_we,
   output logic [ADDR_LEN-1:0] imem_waddr,
   output logic [DATA_LEN-1:0] imem_wdata,
   output logic                cpu_rst,
   output logic                load_done,
   output logic                load_err,
   output logic [15:0]         words_loaded
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t         state;
   logic [7:0]     len_hi;
   logic [15:0]    n_words;
   logic [1:0]     bidx;
   logic [23:0]    asm_q;
   logic [7:0]     csum;
   logic [TW-1:0]  tcnt;

   logic           xfer;
   logic           tmo;
   logic [15:0]    len_new;
   logic           last_word;

   assign xfer      = in_valid && in_ready;
   // Timeout fires on the idle cycle that would bring the counter to TIMEOUT.
   assign tmo       = !xfer && (tcnt == TW'(TIMEOUT - 1));
   assign len_new   = {len_hi, in_data};
   assign last_word = (words_loaded + 16'd1) == n_words;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         in_ready     <= 1'b0;
         imem_we      <= 1'b0;
         imem_waddr   <= '0;
         imem_wdata   <= '0;
         cpu_rst      <= 1'b1;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= '0;
         len_hi       <= '0;
         n_words      <= '0;
         bidx         <= '0;
         asm_q        <= '0;
         csum         <= '0;
         tcnt         <= '0;
      end else begin
         imem_we <= 1'b0;

         // Running XOR and idle counter; the state case below may override
         // both (start clears them, terminal states freeze the counter).
         if (xfer) begin
            csum <= csum ^ in_data;
            tcnt <= '0;
         end else if (state == S_LEN_LO || state == S_DATA || state == S_CHECK) begin
            tcnt <= tcnt + TW'(1);
         end

         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state        <= S_LEN_HI;
                  in_ready     <= 1'b1;
                  cpu_rst      <= 1'b1;
                  load_done    <= 1'b0;
                  load_err     <= 1'b0;
                  words_loaded <= '0;
                  bidx         <= '0;
                  csum         <= '0;
                  tcnt         <= '0;
               end
            end

            S_LEN_HI: begin
               if (xfer) begin
                  len_hi <= in_data;
                  state  <= S_LEN_LO;
               end
            end

            S_LEN_LO: begin
               if (xfer) begin
                  n_words <= len_new;
                  if ({16'd0, len_new} > MAX_WORDS) begin
                     state    <= S_ERROR;
                     in_ready <= 1'b0;
                     load_err <= 1'b1;
                  end else if (len_new == 16'd0) begin
                     state <= S_CHECK;
                  end else begin
                     state <= S_DATA;
                  end
               end else if (tmo) begin
                  state    <= S_ERROR;
                  in_ready <= 1'b0;
                  load_err <= 1'b1;
               end
            end

            S_DATA: begin
               if (xfer) begin
                  asm_q <= {asm_q[15:0], in_data};
                  bidx  <= bidx + 2'd1;
                  if (bidx == 2'd3) begin
                     // Registered here so the write appears the cycle after
                     // the 4th byte, without stalling the stream.
                     imem_we      <= 1'b1;
                     imem_waddr   <= BASE_ADDR + ADDR_LEN'({words_loaded, 2'b00});
                     imem_wdata   <= DATA_LEN'({asm_q, in_data});
                     words_loaded <= words_loaded + 16'd1;
                     if (last_word) begin
                        state <= S_CHECK;
                     end
                  end
               end else if (tmo) begin
                  state    <= S_ERROR;
                  in_ready <= 1'b0;
                  load_err <= 1'b1;
               end
            end

            S_CHECK: begin
               // csum still excludes this byte, so it is the XOR of all
               // preceding frame bytes. The last write has already been
               // issued by the time DONE releases the CPU.
               if (xfer) begin
                  in_ready <= 1'b0;
                  if (in_data == csum) begin
                     state     <= S_DONE;
                     load_done <= 1'b1;
                     cpu_rst   <= 1'b0;
                  end else begin
                     state    <= S_ERROR;
                     load_err <= 1'b1;
                  end
               end else if (tmo) begin
                  state    <= S_ERROR;
                  in_ready <= 1'b0;
                  load_err <= 1'b1;
               end
            end

            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
               cpu_rst  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed self-checking bench for inst_loader
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        load_done;
   logic        load_err;
   logic [15:0] words_loaded;

   int n_vec = 0;
   int n_err = 0;
   int nxfer = 0;
   int wr_released = 0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];

   always #5 clk = ~clk;

   inst_loader #(
      .ADDR_LEN(32), .DATA_LEN(32), .BASE_ADDR(32'h0),
      .MAX_WORDS(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err),
      .words_loaded(words_loaded)
   );

   always @(negedge clk) begin
      if (imem_we) begin
         wa.push_back(imem_waddr);
         wd.push_back(imem_wdata);
         if (!cpu_rst) wr_released++;
      end
      if (in_valid && in_ready) nxfer++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      nxfer = 0;
      wr_released = 0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Presents one byte and returns 1 time unit after the edge that took it.
   task automatic send(input logic [7:0] b);
      int w;
      w = 0;
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic send_nominal(input logic [7:0] check_byte);
      logic [7:0] f [0:9];
      f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      for (int i = 0; i < 10; i++) send(f[i]);
      send(check_byte);
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("rst_done", {31'd0, load_done}, 32'd0);
      chk("rst_words", {16'd0, words_loaded}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Nominal two-word load, back to back.
      clear_log();
      do_start();
      chk("nom_ready_lenhi", {31'd0, in_ready}, 32'd1);
      send_nominal(8'h8B);
      chk("nom_nwr", wa.size(), 32'd2);
      if (wa.size() == 2) begin
         chk("nom_a0", wa[0], 32'h0000_0000);
         chk("nom_d0", wd[0], 32'h2008_0005);
         chk("nom_a1", wa[1], 32'h0000_0004);
         chk("nom_d1", wd[1], 32'hAC08_0000);
      end
      chk("nom_words", {16'd0, words_loaded}, 32'd2);
      chk("nom_done", {31'd0, load_done}, 32'd1);
      chk("nom_err", {31'd0, load_err}, 32'd0);
      chk("nom_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      chk("nom_wr_before_release", wr_released, 32'd0);
      chk("nom_ready_done", {31'd0, in_ready}, 32'd0);

      // Bad checksum.
      clear_log();
      do_start();
      chk("bad_cleared_done", {31'd0, load_done}, 32'd0);
      chk("bad_cpu_rst_start", {31'd0, cpu_rst}, 32'd1);
      send_nominal(8'h8A);
      chk("bad_nwr", wa.size(), 32'd2);
      chk("bad_err", {31'd0, load_err}, 32'd1);
      chk("bad_done", {31'd0, load_done}, 32'd0);
      chk("bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);

      // Oversize word count (MAX_WORDS=4).
      clear_log();
      do_start();
      send(8'h00);
      send(8'h05);
      in_valid = 1'b0;
      chk("ovr_err", {31'd0, load_err}, 32'd1);
      chk("ovr_ready", {31'd0, in_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("ovr_nwr", wa.size(), 32'd0);

      // Zero words with throttled valid.
      clear_log();
      do_start();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send(8'h00);
      end
      in_valid = 1'b0;
      chk("zero_done", {31'd0, load_done}, 32'd1);
      chk("zero_nwr", wa.size(), 32'd0);
      chk("zero_words", {16'd0, words_loaded}, 32'd0);
      chk("zero_nxfer", nxfer, 32'd3);
      chk("zero_cpu_rst", {31'd0, cpu_rst}, 32'd0);

      // Timeout (TIMEOUT=8) after the first data byte.
      clear_log();
      do_start();
      send(8'h00);
      send(8'h02);
      send(8'h20);
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("tmo_not_yet", {31'd0, load_err}, 32'd0);
      @(posedge clk); #1;
      chk("tmo_err", {31'd0, load_err}, 32'd1);
      chk("tmo_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("tmo_nwr", wa.size(), 32'd0);

      // Asynchronous reset mid-frame, then a full reload.
      clear_log();
      do_start();
      send(8'h00);
      send(8'h02);
      send(8'h20);
      send(8'h08);
      send(8'h00);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ready", {31'd0, in_ready}, 32'd0);
      chk("arst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("arst_waddr", imem_waddr, 32'd0);
      chk("arst_wdata", imem_wdata, 32'd0);
      chk("arst_we", {31'd0, imem_we}, 32'd0);
      chk("arst_err", {31'd0, load_err}, 32'd0);
      chk("arst_words", {16'd0, words_loaded}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      clear_log();
      do_start();
      send_nominal(8'h8B);
      chk("rel_done", {31'd0, load_done}, 32'd1);
      chk("rel_words", {16'd0, words_loaded}, 32'd2);
      chk("rel_nwr", wa.size(), 32'd2);
      if (wa.size() == 2) chk("rel_d1", wd[1], 32'hAC08_0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
